hsv2rgb: RTL and testbench



---
 rtl/hsv2rgb_pkg.sv | 31 +++
 rtl/hsv2rgb_if.sv | 33 +++
 rtl/hsv2rgb_div255.sv | 11 +
 rtl/hsv2rgb.sv | 206 ++++++++++++++++++++
 tb/tb_hsv2rgb.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hsv2rgb_pkg.sv
// Shared constants and types for the HSV-to-RGB converter: hue scaling
// helpers parameterised on the number of fractional hue bits, and the
// 3-bit colour-wheel sector encoding.
package hsv2rgb_pkg;

   // Colour-wheel sector, 60 degrees each, 0..5.
   typedef enum logic [2:0] {
      SEC0 = 3'd0,
      SEC1 = 3'd1,
      SEC2 = 3'd2,
      SEC3 = 3'd3,
      SEC4 = 3'd4,
      SEC5 = 3'd5
   } sector_t;

   // 60 degrees in hue fixed-point units.
   function automatic int unsigned hue_h60(input int fixed);
      return 32'd60 << fixed;
   endfunction

   // 360 degrees in hue fixed-point units.
   function automatic int unsigned hue_h360(input int fixed);
      return 32'd360 << fixed;
   endfunction

   // Scale factor mapping an in-sector offset (0..H60-1) onto 0..255 in Q16.
   function automatic int unsigned hue_k(input int fixed);
      return (32'd255 << 16) / hue_h60(fixed);
   endfunction

endpackage

// File: rtl/hsv2rgb_if.sv
// Pixel stream bundle for the HSV-to-RGB converter: HSV input side with
// raster sideband, RGB output side with sideband, valid/ready on both.
interface hsv2rgb_if #(
   parameter int PRECISION = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [PRECISION-1:0] hue;
   logic [7:0]           sat;
   logic [7:0]           val;
   logic                 in_sop;
   logic                 in_eop;

   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           r;
   logic [7:0]           g;
   logic [7:0]           b;
   logic                 out_sop;
   logic                 out_eop;

   // Source/sink side of the converter (drives pixels in, accepts pixels out).
   modport master (
      output in_valid, hue, sat, val, in_sop, in_eop, out_ready,
      input  in_ready, out_valid, r, g, b, out_sop, out_eop
   );

   // Converter side.
   modport slave (
      input  in_valid, hue, sat, val, in_sop, in_eop, out_ready,
      output in_ready, out_valid, r, g, b, out_sop, out_eop
   );
endinterface

// File: rtl/hsv2rgb_div255.sv
// Combinational divide-by-255 without a divider: floor(x/255) for x up to
// 255*255, which is the largest product the converter ever feeds it.
module div255 (
   input  logic [15:0] x,
   output logic [7:0]  y
);
   // (x + (x>>8) + 1) >> 8; the sum stays below 2^16 for x <= 65025.
   always_comb begin
      y = 8'((x + {8'd0, x[15:8]} + 16'd1) >> 8);
   end
endmodule

// File: rtl/hsv2rgb.sv
// Four-stage pipelined HSV-to-RGB converter. Stage 1 wraps the hue and
// splits it into sector and in-sector offset, stage 2 normalises the offset
// to 0..255, stage 3 forms p/q/t, stage 4 picks the per-sector permutation.
// All stages freeze together while the output is stalled.
module hsv2rgb
   import hsv2rgb_pkg::*;
#(
   parameter int FIXED     = 4,
   parameter int PRECISION = 16
) (
   input logic      clk,
   input logic      rst,
   hsv2rgb_if.slave bus
);

   localparam int unsigned H60_I  = hue_h60(FIXED);
   localparam int unsigned H360_I = hue_h360(FIXED);
   localparam int unsigned K_I    = hue_k(FIXED);

   localparam logic [PRECISION-1:0] H60  = H60_I[PRECISION-1:0];
   localparam logic [PRECISION-1:0] H120 = 2 * H60_I;
   localparam logic [PRECISION-1:0] H180 = 3 * H60_I;
   localparam logic [PRECISION-1:0] H240 = 4 * H60_I;
   localparam logic [PRECISION-1:0] H300 = 5 * H60_I;
   localparam logic [PRECISION-1:0] H360 = H360_I[PRECISION-1:0];
   localparam logic [14:0]          K    = K_I[14:0];

   logic stall;
   logic advance;

   assign stall        = bus.out_valid & ~bus.out_ready;
   assign advance      = ~stall;
   assign bus.in_ready = advance;

   // ---------------- stage 1: wrap and sector split ----------------
   logic [PRECISION-1:0] h_wrap;
   logic [PRECISION-1:0] h_base;
   logic [PRECISION-1:0] f_next;
   sector_t              sec_next;

   logic                 s1_valid;
   logic                 s1_sop;
   logic                 s1_eop;
   sector_t              s1_sec;
   logic [PRECISION-1:0] s1_f;
   logic [7:0]           s1_sat;
   logic [7:0]           s1_val;

   // Fold one turn off the hue, then locate the sector with constant compares.
   always_comb begin
      h_wrap   = bus.hue;
      sec_next = SEC0;
      h_base   = '0;
      if (bus.hue >= H360) h_wrap = bus.hue - H360;
      if (h_wrap >= H60)  begin sec_next = SEC1; h_base = H60;  end
      if (h_wrap >= H120) begin sec_next = SEC2; h_base = H120; end
      if (h_wrap >= H180) begin sec_next = SEC3; h_base = H180; end
      if (h_wrap >= H240) begin sec_next = SEC4; h_base = H240; end
      if (h_wrap >= H300) begin sec_next = SEC5; h_base = H300; end
      f_next = h_wrap - h_base;
   end

   // Stage 1 register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid <= bus.in_valid;
         s1_sop   <= bus.in_sop;
         s1_eop   <= bus.in_eop;
         s1_sec   <= sec_next;
         s1_f     <= f_next;
         s1_sat   <= bus.sat;
         s1_val   <= bus.val;
      end
   end

   // ---------------- stage 2: offset normalisation ----------------
   logic [PRECISION+14:0] fk;
   logic [7:0]            fn_next;

   logic                  s2_valid;
   logic                  s2_sop;
   logic                  s2_eop;
   sector_t               s2_sec;
   logic [7:0]            s2_fn;
   logic [7:0]            s2_sat;
   logic [7:0]            s2_val;

   // fn = (f*K) >> 16; f < H60 keeps the result within 0..255.
   always_comb begin
      fk      = {15'd0, s1_f} * {{PRECISION{1'b0}}, K};
      fn_next = 8'(fk >> 16);
   end

   // Stage 2 register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sop   <= s1_sop;
         s2_eop   <= s1_eop;
         s2_sec   <= s1_sec;
         s2_fn    <= fn_next;
         s2_sat   <= s1_sat;
         s2_val   <= s1_val;
      end
   end

   // ---------------- stage 3: p / q / t ----------------
   logic [15:0] p_x;
   logic [15:0] qa_x;
   logic [15:0] q_x;
   logic [15:0] ta_x;
   logic [15:0] t_x;
   logic [7:0]  p_next;
   logic [7:0]  qa;
   logic [7:0]  q_next;
   logic [7:0]  ta;
   logic [7:0]  t_next;

   logic        s3_valid;
   logic        s3_sop;
   logic        s3_eop;
   sector_t     s3_sec;
   logic [7:0]  s3_p;
   logic [7:0]  s3_q;
   logic [7:0]  s3_t;
   logic [7:0]  s3_val;

   // 8x8 products feeding the five dividers.
   always_comb begin
      p_x  = {8'd0, s2_val} * {8'd0, 8'd255 - s2_sat};
      qa_x = {8'd0, s2_sat} * {8'd0, s2_fn};
      q_x  = {8'd0, s2_val} * {8'd0, 8'd255 - qa};
      ta_x = {8'd0, s2_sat} * {8'd0, 8'd255 - s2_fn};
      t_x  = {8'd0, s2_val} * {8'd0, 8'd255 - ta};
   end

   div255 u_div_p  (.x(p_x),  .y(p_next));
   div255 u_div_qa (.x(qa_x), .y(qa));
   div255 u_div_q  (.x(q_x),  .y(q_next));
   div255 u_div_ta (.x(ta_x), .y(ta));
   div255 u_div_t  (.x(t_x),  .y(t_next));

   // Stage 3 register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s3_valid <= 1'b0;
      end else if (advance) begin
         s3_valid <= s2_valid;
         s3_sop   <= s2_sop;
         s3_eop   <= s2_eop;
         s3_sec   <= s2_sec;
         s3_p     <= p_next;
         s3_q     <= q_next;
         s3_t     <= t_next;
         s3_val   <= s2_val;
      end
   end

   // ---------------- stage 4: sector permutation ----------------
   logic [7:0] mr;
   logic [7:0] mg;
   logic [7:0] mb;

   // Map (v, p, q, t) onto (r, g, b) for the pixel's sector.
   always_comb begin
      mr = s3_val;
      mg = s3_t;
      mb = s3_p;
      case (s3_sec)
         SEC0:    begin mr = s3_val; mg = s3_t;   mb = s3_p;   end
         SEC1:    begin mr = s3_q;   mg = s3_val; mb = s3_p;   end
         SEC2:    begin mr = s3_p;   mg = s3_val; mb = s3_t;   end
         SEC3:    begin mr = s3_p;   mg = s3_q;   mb = s3_val; end
         SEC4:    begin mr = s3_t;   mg = s3_p;   mb = s3_val; end
         SEC5:    begin mr = s3_val; mg = s3_p;   mb = s3_q;   end
         default: begin mr = s3_val; mg = s3_t;   mb = s3_p;   end
      endcase
   end

   // Output register; colour only reloads on a valid pixel so bubbles keep
   // the last colour, and sideband is gated by valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_sop   <= 1'b0;
         bus.out_eop   <= 1'b0;
         bus.r         <= '0;
         bus.g         <= '0;
         bus.b         <= '0;
      end else if (advance) begin
         bus.out_valid <= s3_valid;
         bus.out_sop   <= s3_valid & s3_sop;
         bus.out_eop   <= s3_valid & s3_eop;
         if (s3_valid) begin
            bus.r <= mr;
            bus.g <= mg;
            bus.b <= mb;
         end
      end
   end

endmodule

// File: tb/tb_hsv2rgb.sv
// Scoreboard bench for hsv2rgb: a stimulus process computes each pixel's
// expected colour from the HSV definition with plain integer division and
// queues it at handshake; a monitor pops and compares on every output
// transfer, and also checks reset, stall hold and bubble behaviour.
module tb_hsv2rgb;

   localparam int FIXED     = 4;
   localparam int PRECISION = 16;
   localparam int H60       = 60 << FIXED;
   localparam int H360      = 360 << FIXED;
   localparam int LAT       = 4;

   typedef struct {
      int r;
      int g;
      int b;
      bit sop;
      bit eop;
      int stamp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hsv2rgb_if #(.PRECISION(PRECISION)) bus ();

   hsv2rgb #(.FIXED(FIXED), .PRECISION(PRECISION)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t sbq[$];
   exp_t cur_exp;
   exp_t push_e;
   exp_t pop_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_out = 0;
   int   n_stall = 0;
   int   n_sop = 0;
   int   n_eop = 0;
   bit   lat_en = 1'b1;
   logic rst_q = 1'b0;
   logic rst_qq = 1'b0;
   bit   held = 1'b0;
   int   held_r, held_g, held_b, held_sop, held_eop;
   int   last_r = 0, last_g = 0, last_b = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Reference: HSV to RGB from the definition, integer floor division.
   function automatic exp_t model(input int hue, input int s, input int v,
                                  input bit sop, input bit eop);
      exp_t e;
      int h, sec, f, k, fn, p, q, t;
      h   = (hue >= H360) ? hue - H360 : hue;
      sec = h / H60;
      f   = h % H60;
      k   = (255 << 16) / H60;
      fn  = (f * k) >> 16;
      p   = v * (255 - s) / 255;
      q   = v * (255 - s * fn / 255) / 255;
      t   = v * (255 - s * (255 - fn) / 255) / 255;
      case (sec)
         0:       begin e.r = v; e.g = t; e.b = p; end
         1:       begin e.r = q; e.g = v; e.b = p; end
         2:       begin e.r = p; e.g = v; e.b = t; end
         3:       begin e.r = p; e.g = q; e.b = v; end
         4:       begin e.r = t; e.g = p; e.b = v; end
         default: begin e.r = v; e.g = p; e.b = q; end
      endcase
      e.sop   = sop;
      e.eop   = eop;
      e.stamp = 0;
      return e;
   endfunction

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_q  <= rst;
      rst_qq <= rst_q;
   end

   // Scoreboard push at each accepted input; a pending reset flushes it.
   always @(negedge clk) begin
      if (!rst) begin
         sbq.delete();
      end else if (bus.in_valid && bus.in_ready) begin
         push_e       = cur_exp;
         push_e.stamp = cyc;
         sbq.push_back(push_e);
      end
   end

   // Monitor: reset state, flow-control rule, stall hold, bubble hold, data.
   always @(negedge clk) begin
      if (!rst_q) begin
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_rgb", {bus.r, bus.g, bus.b}, 0);
         chk("rst_sideband", {bus.out_sop, bus.out_eop}, 0);
         last_r = 0; last_g = 0; last_b = 0;
         held = 1'b0;
      end else begin
         if (!rst_qq) chk("in_ready_after_rst", bus.in_ready, 1);
         chk("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
         if (!bus.in_ready) n_stall++;
         if (held) begin
            chk("stall_hold_valid", bus.out_valid, 1);
            chk("stall_hold_r", bus.r, held_r);
            chk("stall_hold_g", bus.g, held_g);
            chk("stall_hold_b", bus.b, held_b);
            chk("stall_hold_side", {bus.out_sop, bus.out_eop}, {held_sop[0], held_eop[0]});
         end
         if (bus.out_valid) begin
            if (rst && bus.out_ready) begin
               if (sbq.size() == 0) begin
                  chk("spurious_output", 1, 0);
               end else begin
                  pop_e = sbq.pop_front();
                  chk("r", bus.r, pop_e.r);
                  chk("g", bus.g, pop_e.g);
                  chk("b", bus.b, pop_e.b);
                  chk("out_sop", bus.out_sop, pop_e.sop);
                  chk("out_eop", bus.out_eop, pop_e.eop);
                  if (lat_en) chk("latency", cyc - pop_e.stamp, LAT);
               end
               n_out++;
               if (bus.out_sop) n_sop++;
               if (bus.out_eop) n_eop++;
            end
         end else begin
            chk("bubble_rgb_hold", {bus.r, bus.g, bus.b}, {last_r[7:0], last_g[7:0], last_b[7:0]});
         end
         held     = bus.out_valid && !bus.out_ready && rst;
         held_r   = bus.r;
         held_g   = bus.g;
         held_b   = bus.b;
         held_sop = bus.out_sop;
         held_eop = bus.out_eop;
         last_r   = bus.r;
         last_g   = bus.g;
         last_b   = bus.b;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a pixel (expected value already in cur_exp) until accepted.
   task automatic handshake(input int hue, input int s, input int v,
                            input bit sop, input bit eop);
      int n;
      bit acc;
      int hv;
      hv          = hue;
      bus.hue     = hv[PRECISION-1:0];
      bus.sat     = s[7:0];
      bus.val     = v[7:0];
      bus.in_sop  = sop;
      bus.in_eop  = eop;
      bus.in_valid = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 200) begin
            chk("handshake_timeout", 1, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "input never accepted");
         end
      end
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
   endtask

   task automatic send(input int hue, input int s, input int v,
                       input bit sop, input bit eop);
      cur_exp = model(hue, s, v, sop, eop);
      handshake(hue, s, v, sop, eop);
   endtask

   task automatic send_exp(input int hue, input int s, input int v,
                           input int er, input int eg, input int eb);
      cur_exp.r = er; cur_exp.g = eg; cur_exp.b = eb;
      cur_exp.sop = 1'b0; cur_exp.eop = 1'b0; cur_exp.stamp = 0;
      handshake(hue, s, v, 1'b0, 1'b0);
   endtask

   function automatic int rnd_byte();
      int c;
      c = $urandom_range(0, 7);
      if (c == 0) return 0;
      if (c == 1) return 255;
      return $urandom_range(0, 255);
   endfunction

   task automatic send_rand();
      send($urandom_range(0, 2 * H360 - 1), rnd_byte(), rnd_byte(), 1'b0, 1'b0);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sbq.size() != 0 && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
      idle(2);
   endtask

   initial begin
      #2_000_000;
      chk("global_timeout", 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, s0;
      bit done;
      bus.in_valid  = 1'b1;
      bus.hue       = '0;
      bus.sat       = 8'd255;
      bus.val       = 8'd255;
      bus.in_sop    = 1'b0;
      bus.in_eop    = 1'b0;
      bus.out_ready = 1'b1;
      cur_exp       = model(0, 255, 255, 1'b0, 1'b0);

      // Reset held 3 cycles with input valid asserted.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      idle(2);

      // Primary hues back to back, then wrap and grey.
      send_exp(0,    255, 255, 255, 0,   0);
      send_exp(960,  255, 255, 255, 255, 0);
      send_exp(1920, 255, 255, 0,   255, 0);
      send_exp(480,  255, 255, 255, 127, 0);
      send_exp(5760, 255, 255, 255, 0,   0);
      send_exp(3000, 0,   200, 200, 200, 200);
      // Sector edges and extremes.
      send(H60 - 1,      255, 255, 1'b0, 1'b0);
      send(H360 - 1,     255, 255, 1'b0, 1'b0);
      send(2 * H360 - 1, 128, 77,  1'b0, 1'b0);
      send(5 * H60,      255, 0,   1'b0, 1'b0);
      send(3 * H60 + 7,  1,   255, 1'b0, 1'b0);
      drain();

      // Random pixels with gaps, no backpressure.
      for (int i = 0; i < 60; i++) begin
         send_rand();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Backpressure: 8 pixels, out_ready dropped 5 cycles on output #3.
      lat_en = 1'b0;
      base = n_out;
      s0 = n_stall;
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand();
         end
         begin
            int w;
            w = 0;
            do begin
               @(posedge clk);
               #1;
               w++;
            end while (!(bus.out_valid && n_out == base + 2) && w < 100);
            if (w >= 100) chk("bp_trigger_timeout", 1, 0);
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", n_out - base, 8);
      chk("bp_stall_cycles", n_stall - s0, 5);

      // Random backpressure with random input gaps.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               send_rand();
               if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      lat_en = 1'b1;

      // One 640-pixel row with random input gaps.
      base = n_out;
      s0 = n_sop;
      n_eop = 0;
      for (int i = 0; i < 640; i++) begin
         send($urandom_range(0, H360 - 1), rnd_byte(), rnd_byte(), i == 0, i == 639);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      drain();
      chk("row_count", n_out - base, 640);
      chk("row_sop_count", n_sop - s0, 1);
      chk("row_eop_count", n_eop, 1);

      // Reset with three pixels in flight.
      send_rand();
      send_rand();
      send_rand();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(8);
      base = n_out;
      send_exp(1920, 255, 255, 0, 255, 0);
      drain();
      chk("post_rst_count", n_out - base, 1);

      finish_run();
   end

endmodule
